// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: op encodings,
// op width and the sequencer state type.
package pc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_HOLD   = 3'd0,
        OP_INC    = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_e;

    typedef enum logic {
        ST_HOLDOFF = 1'b0,
        ST_RUN     = 1'b1
    } seq_state_e;

endpackage

// File: rtl/pc_return_stack.sv
// LIFO of return addresses. Pushes when full and pops when empty are
// ignored here; the sequencer records them as overflow/underflow.
module pc_return_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             i_push,
    input  logic                             i_pop,
    input  logic [ADDR_W-1:0]                i_data,
    output logic [ADDR_W-1:0]                o_top,
    output logic [$clog2(STACK_DEPTH+1)-1:0] o_depth,
    output logic                             o_full,
    output logic                             o_empty
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
    logic [DW-1:0]     r_depth;
    logic [IW-1:0]     w_wrIdx;
    logic [IW-1:0]     w_rdIdx;
    logic              w_doPush;
    logic              w_doPop;

    // The write slot is the current depth; the top entry sits one below it.
    assign w_wrIdx  = r_depth[IW-1:0];
    assign w_rdIdx  = w_wrIdx - IW'(1);
    assign o_full   = (r_depth == DW'(STACK_DEPTH));
    assign o_empty  = (r_depth == '0);
    assign w_doPush = i_push && !o_full;
    assign w_doPop  = i_pop && !o_empty;
    assign o_depth  = r_depth;
    assign o_top    = r_mem[w_rdIdx];

    // Entry storage needs no reset: slots above depth are never read as valid.
    always_ff @(posedge clock) begin
        if (w_doPush) begin
            r_mem[w_wrIdx] <= i_data;
        end
    end

    // Occupancy counter; reset empties the stack regardless of push/pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_depth <= '0;
        end else if (w_doPush) begin
            r_depth <= r_depth + DW'(1);
        end else if (w_doPop) begin
            r_depth <= r_depth - DW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: pc register, post-reset holdoff cycle,
// next-pc selection and sticky stack error flags around a return stack.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                ADDR_W      = 11,
    parameter int                STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [OP_W-1:0]                  op,
    input  logic [ADDR_W-1:0]                target,
    input  logic                             stall,
    output logic [ADDR_W-1:0]                pc,
    output logic                             pc_valid,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             overflow,
    output logic                             underflow
);

    seq_state_e        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_pcValid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_run;
    logic              w_isCall;
    logic              w_isRet;
    logic [ADDR_W-1:0] w_pcInc;
    logic [ADDR_W-1:0] w_nextPc;
    logic [ADDR_W-1:0] w_top;
    logic              w_full;
    logic              w_empty;

    // The stack only moves on an unstalled cycle after holdoff.
    assign w_run    = (r_state == ST_RUN) && !stall;
    assign w_isCall = (op == OP_CALL);
    assign w_isRet  = (op == OP_RET);
    assign w_pcInc  = r_pc + ADDR_W'(1);

    pc_return_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_run && w_isCall),
        .i_pop   (w_run && w_isRet),
        .i_data  (w_pcInc),
        .o_top   (w_top),
        .o_depth (depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-pc selection; a RET on an empty stack falls through to pc+1.
    always_comb begin
        w_nextPc = r_pc;
        case (op)
            OP_INC:    w_nextPc = w_pcInc;
            OP_BRANCH: w_nextPc = target;
            OP_CALL:   w_nextPc = target;
            OP_RET:    w_nextPc = w_empty ? w_pcInc : w_top;
            default:   w_nextPc = r_pc;
        endcase
    end

    // Holdoff/run FSM with pc register and sticky flags; reset overrides all.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_HOLDOFF;
            r_pc        <= RESET_VEC;
            r_pcValid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLDOFF: begin
                    r_state   <= ST_RUN;
                    r_pcValid <= 1'b1;
                end
                default: begin
                    if (!stall) begin
                        r_pc <= w_nextPc;
                        if (w_isCall && w_full) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_isRet && w_empty) begin
                            r_underflow <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign pc_valid  = r_pcValid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, giving the program-address width in bits.
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4, giving the number of return-address entries (min 1).
REQ-003 The block SHALL have parameter RESET_VEC, default 0, giving the first instruction address.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port op, input, 3 bits: sequencing operation for this cycle.
REQ-007 The block SHALL have port target, input, ADDR_W bits: destination for BRANCH/CALL.
REQ-008 The block SHALL have port stall, input, 1 bit: freezes all state when high.
REQ-009 The block SHALL have port pc, output, ADDR_W bits: current instruction address.
REQ-010 The block SHALL have port pc_valid, output, 1 bit: pc addresses an instruction to execute this cycle.
REQ-011 The block SHALL have port depth, output, $clog2(STACK_DEPTH+1) bits: occupied stack entries.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky, CALL attempted with stack full.
REQ-013 The block SHALL have port underflow, output, 1 bit: sticky, RET attempted with stack empty.

Function
REQ-014 The op encodings SHALL be: 0 HOLD, 1 INC, 2 BRANCH, 3 CALL, 4 RET; codes 5-7 SHALL behave as HOLD.
REQ-015 After reset, the block SHALL spend exactly one holdoff cycle with pc=RESET_VEC and pc_valid=0, ignoring op and stall, so that address RESET_VEC is never skipped.
REQ-016 From the cycle after holdoff, pc_valid SHALL be 1 and stay 1 until the next reset.
REQ-017 With pc_valid=1 and stall=1, pc, the stack, depth and both flags SHALL hold their values.
REQ-018 With pc_valid=1 and stall=0, next pc SHALL be: HOLD pc; INC pc+1; BRANCH target; CALL target; RET the popped top-of-stack.
REQ-019 All pc arithmetic SHALL be modulo 2^ADDR_W (INC from all-ones yields 0, no flag).
REQ-020 CALL with depth<STACK_DEPTH SHALL push pc+1 (mod 2^ADDR_W) and increment depth in the same edge.
REQ-021 CALL with depth=STACK_DEPTH SHALL still load target, SHALL leave the stack and depth unchanged, and SHALL set overflow.
REQ-022 RET with depth>0 SHALL load the top entry and decrement depth.
REQ-023 RET with depth=0 SHALL advance pc to pc+1, leave depth at 0, and set underflow.
REQ-024 The stack SHALL be LIFO; entries beyond depth are don't-care and SHALL NOT be observable.
REQ-025 Outputs SHALL be registered; op/target SHALL affect pc one rising edge later (latency 1).
REQ-026 overflow and underflow SHALL clear only on reset.

Reset
REQ-027 Reset asserted at any rising edge SHALL force pc=RESET_VEC, pc_valid=0, depth=0, overflow=0, underflow=0, and re-arm the holdoff cycle, overriding stall and op (including mid-CALL/RET).
REQ-028 Reset held for several cycles SHALL keep all outputs at their reset values; holdoff SHALL begin at the first edge with reset low.

Structure
REQ-029 The op encodings and the op width constant SHALL live in the shared package pc_pkg.
REQ-030 The return stack SHALL be a sub-module pc_return_stack (parameters ADDR_W, STACK_DEPTH; push/pop/data/depth/full/empty).
REQ-031 pc_sequencer SHALL contain the pc register, holdoff state, next-pc selection and sticky flags.

Verification
REQ-032 The bench SHALL check holdoff: reset 2 cycles, then op=INC continuously -> pc sequence 0,0,1,2,3; pc_valid 0,1,1,1,1.
REQ-033 The bench SHALL check wrap: BRANCH target=0x7FF, then INC -> pc 0x7FF then 0x000, no flags.
REQ-034 The bench SHALL check call/return: at pc=5, CALL target=0x100; INC; RET -> pc 0x100, 0x101, 6; depth 1,1,0.
REQ-035 The bench SHALL check overflow/underflow: 5 CALLs (depth 4) -> 5th jumps, depth stays 4, overflow=1; 5 RETs -> 4 pops in LIFO order, 5th gives pc+1, underflow=1.
REQ-036 The bench SHALL check stall: stall=1 for 3 cycles with op=CALL -> pc, depth, flags unchanged; release -> CALL takes effect next edge.
REQ-037 The bench SHALL check reset mid-operation: reset at depth=3 with overflow=1 -> pc=RESET_VEC, depth=0, flags 0, holdoff repeats.
